// File: rtl/fir_divide.sv
// fir_divide: sequential signed divider (sign-magnitude restoring, one
// quotient bit per clock). Returns a saturated Q_WIDTH-bit quotient and a
// D_WIDTH-bit remainder whose sign follows the dividend.
// Optional build macro FIR_DIVIDE_ROUND_EN: round the quotient half away
// from zero instead of truncating toward zero.
module fir_divide #(
  parameter int N_WIDTH = 34,
  parameter int D_WIDTH = 18,
  parameter int Q_WIDTH = 16
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Start,
  input  logic [N_WIDTH-1:0] N,
  input  logic [D_WIDTH-1:0] D,
  output logic               Ready,
  output logic               Valid,
  output logic [Q_WIDTH-1:0] Q,
  output logic [D_WIDTH-1:0] R,
  output logic               Overflow,
  output logic               DivZero
);

  localparam int CNT_W = $clog2(N_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ABS,
    S_DIV,
    S_FIX
  } state_e;

  // Saturation limits on the quotient magnitude (N_WIDTH+1 bits so the
  // rounding increment never wraps).
  localparam logic [N_WIDTH:0] POS_LIM = (N_WIDTH+1)'(2**(Q_WIDTH-1) - 1);
  localparam logic [N_WIDTH:0] NEG_LIM = (N_WIDTH+1)'(2**(Q_WIDTH-1));
  localparam logic [Q_WIDTH-1:0] Q_POS_SAT = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] Q_NEG_SAT = {1'b1, {(Q_WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [N_WIDTH-1:0] n_q, n_d;       // captured dividend
  logic [D_WIDTH-1:0] d_q, d_d;       // captured divisor
  logic [N_WIDTH-1:0] quo_q, quo_d;   // |N| shifts out, quotient shifts in
  logic [D_WIDTH-1:0] dabs_q, dabs_d; // |D|
  logic [D_WIDTH-1:0] rem_q, rem_d;   // partial remainder, always < |D|
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [Q_WIDTH-1:0] q_q, q_d;
  logic [D_WIDTH-1:0] r_q, r_d;
  logic               ovf_q, ovf_d;
  logic               divzero_q, divzero_d;

  // Restoring-step and result-fixup datapath signals.
  logic [D_WIDTH:0]   shifted;
  logic [D_WIDTH:0]   trial;
  logic [N_WIDTH:0]   mag;
  logic [Q_WIDTH-1:0] q_fix;
  logic               ovf_fix;

  assign Ready    = (state_q == S_IDLE);
  assign Valid    = valid_q;
  assign Q        = q_q;
  assign R        = r_q;
  assign Overflow = ovf_q;
  assign DivZero  = divzero_q;

  // Quotient fixup: optional rounding, saturation and sign application.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    mag     = {1'b0, quo_q};
    q_fix   = '0;
    ovf_fix = 1'b0;
`ifdef FIR_DIVIDE_ROUND_EN
    if (!dz_q && ({1'b0, rem_q, 1'b0} >= {2'b00, dabs_q})) begin
      mag = {1'b0, quo_q} + (N_WIDTH+1)'(1);
    end
`endif
    if (dz_q) begin
      q_fix   = rneg_q ? Q_NEG_SAT : Q_POS_SAT;
      ovf_fix = 1'b1;
    end else if (!qneg_q) begin
      if (mag > POS_LIM) begin
        q_fix   = Q_POS_SAT;
        ovf_fix = 1'b1;
      end else begin
        q_fix = mag[Q_WIDTH-1:0];
      end
    end else begin
      if (mag > NEG_LIM) begin
        q_fix   = Q_NEG_SAT;
        ovf_fix = 1'b1;
      end else begin
        // A magnitude of exactly 2^(Q_WIDTH-1) negates to itself, which is
        // the correct most-negative code.
        q_fix = -mag[Q_WIDTH-1:0];
      end
    end
  end

  // Next-state and datapath control for IDLE -> ABS -> DIV -> FIX.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    quo_d     = quo_q;
    dabs_d    = dabs_q;
    rem_d     = rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    q_d       = q_q;
    r_d       = r_q;
    ovf_d     = ovf_q;
    divzero_d = divzero_q;

    shifted = {rem_q, quo_q[N_WIDTH-1]};
    trial   = shifted - {1'b0, dabs_q};

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          n_d     = N;
          d_d     = D;
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        // Negation in the unsigned N_WIDTH domain keeps -2^(N_WIDTH-1)
        // as the correct magnitude 2^(N_WIDTH-1).
        quo_d   = n_q[N_WIDTH-1] ? -n_q : n_q;
        dabs_d  = d_q[D_WIDTH-1] ? -d_q : d_q;
        qneg_d  = n_q[N_WIDTH-1] ^ d_q[D_WIDTH-1];
        rneg_d  = n_q[N_WIDTH-1];
        dz_d    = (d_q == '0);
        rem_d   = '0;
        cnt_d   = CNT_W'(N_WIDTH - 1);
        state_d = S_DIV;
      end
      S_DIV: begin
        if (!trial[D_WIDTH]) begin
          rem_d = trial[D_WIDTH-1:0];
          quo_d = {quo_q[N_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[D_WIDTH-1:0];
          quo_d = {quo_q[N_WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        q_d       = q_fix;
        ovf_d     = ovf_fix;
        divzero_d = dz_q;
        r_d       = dz_q ? '0 : (rneg_q ? -rem_q : rem_q);
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= S_IDLE;
      n_q       <= '0;
      d_q       <= '0;
      quo_q     <= '0;
      dabs_q    <= '0;
      rem_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      ovf_q     <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      d_q       <= d_d;
      quo_q     <= quo_d;
      dabs_q    <= dabs_d;
      rem_q     <= rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      q_q       <= q_d;
      r_q       <= r_d;
      ovf_q     <= ovf_d;
      divzero_q <= divzero_d;
    end
  end

endmodule

// File: tb/tb_fir_divide.sv
// tb_fir_divide: directed vectors for fir_divide. The driver pushes the
// hand-computed result and due cycle into a scoreboard queue; a monitor
// pops and compares whenever Valid is seen.
module tb_fir_divide;

`ifdef FIR_DIVIDE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        Clk;
  logic        nReset;
  logic        Start;
  logic [33:0] N;
  logic [17:0] D;
  logic        Ready;
  logic        Valid;
  logic [15:0] Q;
  logic [17:0] R;
  logic        Overflow;
  logic        DivZero;

  typedef struct packed {
    logic [33:0] n;
    logic [17:0] d;
    logic [15:0] q;
    logic [17:0] r;
    logic        ovf;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [17:0] r;
    logic        ovf;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fir_divide dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .Start    (Start),
    .N        (N),
    .D        (D),
    .Ready    (Ready),
    .Valid    (Valid),
    .Q        (Q),
    .R        (R),
    .Overflow (Overflow),
    .DivZero  (DivZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [33:0] n, input logic [17:0] d,
                              input logic [15:0] q, input logic [17:0] r,
                              input logic ovf, input logic dz);
    vec_t v;
    v.n = n; v.d = d; v.q = q; v.r = r; v.ovf = ovf; v.dz = dz;
    return v;
  endfunction

  // Queue one expected result, due at the negedge 37 cycles after drive.
  task automatic expect_result(input vec_t v, input int due);
    exp_t e;
    e.q = v.q; e.r = v.r; e.ovf = v.ovf; e.dz = v.dz; e.due = due;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!Ready && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (!Ready) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: Ready stayed 0 at cycle %0d", cyc);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge Clk);
      t++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL valid_timeout: %0d results outstanding at cycle %0d", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    N = v.n;
    D = v.d;
    Start = 1'b1;
    expect_result(v, cyc + 37);
    @(negedge Clk);
    Start = 1'b0;
    wait_drain(100);
  endtask

  // Monitor: compare every Valid pulse against the head of the scoreboard.
  always @(negedge Clk) begin
    if (nReset && Valid) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_valid: Valid with empty scoreboard at cycle %0d Q=%0h", cyc, Q);
      end else begin
        mon_e = sb.pop_front();
        check("q", 64'(Q), 64'(mon_e.q));
        check("r", 64'(R), 64'(mon_e.r));
        check("overflow", 64'(Overflow), 64'(mon_e.ovf));
        check("divzero", 64'(DivZero), 64'(mon_e.dz));
        check("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vec_t v;
    nReset = 1'b0;
    Start  = 1'b0;
    N      = '0;
    D      = '0;

    vecs.push_back(mk(34'sd100, 18'sd7, 16'sd14, 18'sd2, 1'b0, 1'b0));
    vecs.push_back(mk(-34'sd100, 18'sd7, -16'sd14, -18'sd2, 1'b0, 1'b0));
    vecs.push_back(mk(34'sd11, -18'sd2, ROUND ? -16'sd6 : -16'sd5, 18'sd1, 1'b0, 1'b0));
    vecs.push_back(mk(34'sd5, 18'sd0, 16'h7FFF, 18'sd0, 1'b1, 1'b1));
    vecs.push_back(mk(-34'sd5, 18'sd0, 16'h8000, 18'sd0, 1'b1, 1'b1));
    vecs.push_back(mk(34'sd1048576, 18'sd1, 16'h7FFF, 18'sd0, 1'b1, 1'b0));
    vecs.push_back(mk(-34'sd32768, 18'sd1, 16'h8000, 18'sd0, 1'b0, 1'b0));
    vecs.push_back(mk(34'h2_0000_0000, 18'h20000, 16'h7FFF, 18'sd0, 1'b1, 1'b0));
    vecs.push_back(mk(34'sd32767, 18'sd1, 16'h7FFF, 18'sd0, 1'b0, 1'b0));
    vecs.push_back(mk(34'sd32768, -18'sd1, 16'h8000, 18'sd0, 1'b0, 1'b0));
    vecs.push_back(mk(-34'sd32769, 18'sd1, 16'h8000, 18'sd0, 1'b1, 1'b0));
    vecs.push_back(mk(34'sd1000, 18'h20000, 16'sd0, 18'sd1000, 1'b0, 1'b0));
    vecs.push_back(mk(-34'sd300000, 18'h20000, 16'sd2, -18'sd37856, 1'b0, 1'b0));
    vecs.push_back(mk(34'sd5, 18'sd2, ROUND ? 16'sd3 : 16'sd2, 18'sd1, 1'b0, 1'b0));
    vecs.push_back(mk(34'h2_0000_0000, 18'sd3, 16'h8000, -18'sd2, 1'b1, 1'b0));

    // Reset state, while held and after release.
    repeat (2) @(negedge Clk);
    check("rst_ready", 64'(Ready), 64'd1);
    check("rst_valid", 64'(Valid), 64'd0);
    check("rst_q", 64'(Q), 64'd0);
    check("rst_r", 64'(R), 64'd0);
    check("rst_ovf", 64'(Overflow), 64'd0);
    check("rst_dz", 64'(DivZero), 64'd0);
    nReset = 1'b1;
    @(negedge Clk);
    check("idle_ready", 64'(Ready), 64'd1);

    // Directed vectors.
    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        repeat (5) @(negedge Clk);
        check("q_hold", 64'(Q), 64'd14);
      end
    end

    // Start pulsed while busy: only the first operands produce a result.
    wait_ready();
    v = mk(34'sd100, 18'sd7, 16'sd14, 18'sd2, 1'b0, 1'b0);
    N = v.n;
    D = v.d;
    Start = 1'b1;
    expect_result(v, cyc + 37);
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(negedge Clk);
      N = -34'sd5;
      D = 18'sd0;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
    end
    wait_drain(100);
    repeat (45) @(negedge Clk);

    // Start held high: back-to-back divisions every 37 clocks.
    wait_ready();
    v = mk(-34'sd100, 18'sd7, -16'sd14, -18'sd2, 1'b0, 1'b0);
    N = v.n;
    D = v.d;
    Start = 1'b1;
    k = cyc;
    expect_result(v, k + 37);
    expect_result(v, k + 74);
    expect_result(v, k + 111);
    while (cyc < k + 80) @(negedge Clk);
    Start = 1'b0;
    wait_drain(150);
    repeat (45) @(negedge Clk);

    // Reset pulse in DIV cycle 10 aborts the division with no Valid.
    wait_ready();
    N = 34'sd100;
    D = 18'sd7;
    Start = 1'b1;
    k = cyc;
    @(negedge Clk);
    Start = 1'b0;
    while (cyc < k + 11) @(negedge Clk);
    nReset = 1'b0;
    #1;
    check("abort_ready", 64'(Ready), 64'd1);
    check("abort_valid", 64'(Valid), 64'd0);
    check("abort_q", 64'(Q), 64'd0);
    check("abort_r", 64'(R), 64'd0);
    check("abort_ovf", 64'(Overflow), 64'd0);
    check("abort_dz", 64'(DivZero), 64'd0);
    @(negedge Clk);
    nReset = 1'b1;
    repeat (50) @(negedge Clk);
    run_vec(mk(34'sd100, 18'sd7, 16'sd14, 18'sd2, 1'b0, 1'b0));

    repeat (5) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_divide.md
Name: fir_divide

Overview:
- Sequential signed divider for the receiver graphics datapath; the inverse operation of the FIR product stage.
- Takes a 34-bit signed product-domain value and an 18-bit signed coefficient, and returns a saturated 16-bit signed quotient plus the remainder.
- Uses sign-magnitude restoring division, one quotient bit per clock, with a Start/Ready/Valid handshake.
- Used for gain normalisation ahead of the display scaler.

Parameters:
N_WIDTH, 34, dividend width (signed two's complement)
D_WIDTH, 18, divisor width (signed)
Q_WIDTH, 16, output quotient width (signed, saturated)

Ports:
Clk  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
Start  input  1  request; sampled only while Ready=1
N  input  N_WIDTH  dividend, captured on accepted Start
D  input  D_WIDTH  divisor, captured on accepted Start
Ready  output  1  idle, can accept Start
Valid  output  1  one-cycle pulse, results valid
Q  output  Q_WIDTH  signed quotient, truncated toward zero, saturated
R  output  D_WIDTH  signed remainder, sign follows dividend
Overflow  output  1  quotient saturated (includes divide-by-zero)
DivZero  output  1  divisor was zero

Behaviour:
- One clock Clk. Reset nReset is asynchronous and active-low.
- Reset values: Ready=1, Valid=0, Q=0, R=0, Overflow=0, DivZero=0, state=IDLE. Asserting nReset mid-operation aborts the division immediately; no Valid is produced.
- State machine: IDLE -> ABS -> DIV -> FIX -> IDLE.
  - IDLE: Ready=1. On Start=1, register N and D, clear Ready, go to ABS.
  - ABS: compute |N| (N_WIDTH bits) and |D| (D_WIDTH bits), sign_q = N[msb]^D[msb], sign_r = N[msb], dz = (D==0). Load the iteration counter with N_WIDTH-1. Go to DIV.
  - DIV: one restoring step per clock. Shift partial remainder (D_WIDTH+1 bits) left with the next dividend MSB, then trial-subtract |D|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0. Counter reaches 0 -> go to FIX (exactly N_WIDTH cycles in DIV).
  - FIX: apply signs and saturate, register Q/R/Overflow/DivZero, pulse Valid=1 for this one cycle, set Ready=1 and return to IDLE.
- Latency: Valid is high exactly N_WIDTH+2 clocks after the edge that accepts Start (36 by default). Throughput is one division per N_WIDTH+3 clocks; Start may be re-asserted in the cycle Valid is high only if Ready=1 that cycle.
- Start while Ready=0 is ignored; no queuing.
- Q, R, Overflow and DivZero hold their values until the next FIX.
- Saturation:
  - Positive result with magnitude > 2^(Q_WIDTH-1)-1 -> Q=0x7FFF, Overflow=1.
  - Negative result with magnitude > 2^(Q_WIDTH-1) -> Q=0x8000, Overflow=1.
  - A negative magnitude of exactly 2^(Q_WIDTH-1) gives 0x8000 with Overflow=0.
- Divide by zero:
  - DivZero=1 and Overflow=1.
  - Q=0x7FFF if N>=0, else 0x8000.
  - R=0.
  - The full iteration still runs, so latency is unchanged.
- Remainder: |R| < |D|. R is negated when sign_r=1. The remainder never overflows D_WIDTH, including at D = -2^(D_WIDTH-1).
- The most negative dividend -2^(N_WIDTH-1) must yield the correct magnitude; abs is computed as unsigned, not sign-extended.

Optional Feature:
FIR_DIVIDE_ROUND_EN:
- Defined: the quotient rounds half away from zero.
  - In FIX, if 2*|Rem| >= |D| and dz=0, the magnitude is incremented before sign application and saturation.
  - R still reports the truncation remainder.
  - Latency is unchanged.
- Undefined: truncation toward zero only, and the rounding adder is absent.

Test Plan:
- N=100, D=7 -> after 36 clocks Valid=1: Q=14 (0x000E), R=2, Overflow=0, DivZero=0. With ROUND_EN: Q=14.
- N=-100, D=7 -> Q=-14 (0xFFF2), R=-2. N=11, D=-2 -> Q=-5, R=1. With ROUND_EN, N=11, D=-2 -> Q=-6.
- N=5, D=0 -> Q=0x7FFF, R=0, DivZero=1, Overflow=1. N=-5, D=0 -> Q=0x8000, DivZero=1.
- N=2^20, D=1 -> Q=0x7FFF, Overflow=1. N=-32768, D=1 -> Q=0x8000, Overflow=0. N=-2^33, D=-2^17 -> Q=0x7FFF, Overflow=1.
- Start pulsed repeatedly during DIV -> ignored: exactly one Valid, with results from the first operands. Start held high continuously -> back-to-back divisions, one per 37 clocks.
- nReset low for 1 clock at DIV cycle 10 -> all outputs return to reset values immediately and no Valid is seen. A following N=100, D=7 completes normally.
